audio_transmit: RTL and testbench

AUDIO_TRANSMIT -- requirements
Module: audio_transmit

---
 rtl/audio_transmit.sv | 175 +++++++++++++++++
 tb/tb_audio_transmit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_transmit.sv
// audio_transmit: buffers 16-bit audio samples in a 4-deep FIFO and sends
// each one as a framed serial word (sclk/mosi/active), MSB first.  A frame is
// a setup half-period, sixteen sclk pulses, a hold half-period and then an
// inter-frame gap.  This gives 33*CLK_DIV cycles of active_out high, followed
// by at least GAP_CYCLES cycles low.
module audio_transmit #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk_25mhz,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] audio_in,
    input  logic        audio_valid,
    output logic        audio_ready,
    output logic        sclk_out,
    output logic        mosi_out,
    output logic        active_out,
    output logic        frame_done,
    output logic [2:0]  fifo_level
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Terminal counts for the shared cycle counter.  The gap terminal is
    // GAP_CYCLES-2 because leaving GAP and starting the next frame from IDLE
    // together use two of the GAP_CYCLES low cycles.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 2);

    logic [15:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        push;
    logic        pop;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  rise_cnt;
    logic [15:0] shift_reg;

    assign audio_ready = (fifo_level < 3'd4);
    assign push        = audio_valid && audio_ready;
    assign pop         = (state == IDLE) && enable && (fifo_level != 3'd0);

    // Sample storage.  It needs no reset because the pointers and the level
    // decide which entries are meaningful.
    always_ff @(posedge clk_25mhz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= audio_in;
        end
    end

    // FIFO pointers and occupancy.  A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_level <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 3'd1;
                2'b01:   fifo_level <= fifo_level - 3'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame sequencer: every serial output is registered here so the receiver sees no glitches.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            rise_cnt   <= 5'd0;
            shift_reg  <= 16'd0;
            sclk_out   <= 1'b0;
            mosi_out   <= 1'b0;
            active_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_out <= 1'b0;
                    div_cnt  <= 8'd0;
                    if (pop) begin
                        shift_reg  <= fifo_mem[rd_ptr];
                        mosi_out   <= fifo_mem[rd_ptr][15];
                        active_out <= 1'b1;
                        rise_cnt   <= 5'd0;
                        state      <= SETUP;
                    end else begin
                        active_out <= 1'b0;
                        mosi_out   <= 1'b0;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 8'd0;
                        sclk_out <= 1'b1;
                        rise_cnt <= 5'd1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        if (sclk_out) begin
                            // Falling edge: present the next bit.  After the
                            // sixteenth bit, stop without another rising edge.
                            sclk_out <= 1'b0;
                            if (rise_cnt == 5'd16) begin
                                state <= HOLD;
                            end else begin
                                shift_reg <= {shift_reg[14:0], 1'b0};
                                mosi_out  <= shift_reg[14];
                            end
                        end else begin
                            sclk_out <= 1'b1;
                            rise_cnt <= rise_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= 8'd0;
                        active_out <= 1'b0;
                        mosi_out   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    div_cnt    <= 8'd0;
                    sclk_out   <= 1'b0;
                    mosi_out   <= 1'b0;
                    active_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_transmit.sv
// tb_audio_transmit: drives two audio_transmit instances.  Instance 0 uses the
// default timing and instance 1 uses CLK_DIV=2, GAP_CYCLES=2.  The bench
// predicts every output cycle by cycle from a frame-level model: a queue of
// accepted samples, frame start times, and waveform phase arithmetic.
module tb_audio_transmit;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        en    [2];
    logic        val   [2];
    logic [15:0] din   [2];
    logic        ready [2];
    logic        sck   [2];
    logic        mo    [2];
    logic        act   [2];
    logic        fd    [2];
    logic [2:0]  lvl   [2];

    int n_checks;
    int n_fail;
    int cyc;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    logic        in_frame  [2];
    logic        prev_push [2];
    logic        prev_en   [2];
    logic        prev_sck  [2];
    logic [15:0] prev_data [2];
    logic [15:0] cur_word  [2];
    logic [15:0] rx        [2];
    logic [15:0] last_rx   [2];
    int          t0        [2];
    int          last_fall [2];
    int          rises     [2];
    int          frames_done [2];

    // 25 MHz-style free-running clock; only the edge spacing matters here.
    always #5 clk = ~clk;

    audio_transmit dut0 (
        .clk_25mhz  (clk),
        .reset_n    (rst_n[0]),
        .enable     (en[0]),
        .audio_in   (din[0]),
        .audio_valid(val[0]),
        .audio_ready(ready[0]),
        .sclk_out   (sck[0]),
        .mosi_out   (mo[0]),
        .active_out (act[0]),
        .frame_done (fd[0]),
        .fifo_level (lvl[0])
    );

    audio_transmit #(.CLK_DIV(2), .GAP_CYCLES(2)) dut1 (
        .clk_25mhz  (clk),
        .reset_n    (rst_n[1]),
        .enable     (en[1]),
        .audio_in   (din[1]),
        .audio_valid(val[1]),
        .audio_ready(ready[1]),
        .sclk_out   (sck[1]),
        .mosi_out   (mo[1]),
        .active_out (act[1]),
        .frame_done (fd[1]),
        .fifo_level (lvl[1])
    );

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    function automatic int gap_of(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] qpop(input int u);
        if (u == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int u, input logic [15:0] d);
        if (u == 0) q0.push_back(d);
        else q1.push_back(d);
    endfunction

    function automatic void qclear(input int u);
        if (u == 0) q0.delete();
        else q1.delete();
    endfunction

    task automatic checkOutput(input string tag, input int u,
                               input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s (dut%0d, cycle %0d): got %0h, expected %0h",
                   tag, u, cyc, got, exp);
        end
    endtask

    // One negedge step of the reference model for instance u
    task automatic monitorUnit(input int u);
        int   d;
        int   g;
        int   ph;
        logic start_now;
        logic check_mo;
        logic exp_act;
        logic exp_sck;
        logic exp_mo;
        logic exp_fd;
        d  = div_of(u);
        g  = gap_of(u);
        ph = 0;
        if (!rst_n[u]) begin
            checkOutput("rst_active", u, 32'(act[u]), 32'd0);
            checkOutput("rst_sclk",   u, 32'(sck[u]), 32'd0);
            checkOutput("rst_mosi",   u, 32'(mo[u]),  32'd0);
            checkOutput("rst_done",   u, 32'(fd[u]),  32'd0);
            checkOutput("rst_level",  u, 32'(lvl[u]), 32'd0);
            qclear(u);
            in_frame[u]  = 1'b0;
            last_fall[u] = -1000;
            prev_push[u] = 1'b0;
            prev_en[u]   = en[u];
            prev_sck[u]  = 1'b0;
            rises[u]     = 0;
        end else begin
            // A frame starts at the first edge where the sequencer is free,
            // enable is high and the buffer holds a sample.
            start_now = !in_frame[u] && prev_en[u] && (qsize(u) > 0) &&
                        (cyc - last_fall[u] >= g);
            if (start_now) begin
                cur_word[u] = qpop(u);
                t0[u]       = cyc;
                in_frame[u] = 1'b1;
                rx[u]       = 16'd0;
                rises[u]    = 0;
            end
            if (prev_push[u]) qpush(u, prev_data[u]);

            checkOutput("fifo_level",  u, 32'(lvl[u]),   32'(qsize(u)));
            checkOutput("audio_ready", u, 32'(ready[u]), 32'(qsize(u) < 4));

            exp_act  = 1'b0;
            exp_sck  = 1'b0;
            exp_mo   = 1'b0;
            exp_fd   = 1'b0;
            check_mo = 1'b1;
            if (in_frame[u]) begin
                ph = cyc - t0[u];
                if (ph < 33 * d) begin
                    exp_act = 1'b1;
                    exp_sck = (ph < 32 * d) && (((ph / d) % 2) == 1);
                    if (ph < 32 * d) exp_mo = cur_word[u][15 - ph / (2 * d)];
                    else check_mo = 1'b0;
                end else begin
                    exp_fd = 1'b1;
                end
            end

            if (sck[u] && !prev_sck[u] && act[u]) begin
                rx[u]    = {rx[u][14:0], mo[u]};
                rises[u] = rises[u] + 1;
            end

            checkOutput("active_out", u, 32'(act[u]), 32'(exp_act));
            checkOutput("sclk_out",   u, 32'(sck[u]), 32'(exp_sck));
            checkOutput("frame_done", u, 32'(fd[u]),  32'(exp_fd));
            if (check_mo) checkOutput("mosi_out", u, 32'(mo[u]), 32'(exp_mo));

            if (in_frame[u] && ph == 33 * d) begin
                in_frame[u]    = 1'b0;
                last_fall[u]   = cyc;
                frames_done[u] = frames_done[u] + 1;
                last_rx[u]     = rx[u];
                checkOutput("rx_word",   u, 32'(rx[u]),    32'(cur_word[u]));
                checkOutput("rise_cnt",  u, 32'(rises[u]), 32'd16);
            end

            prev_push[u] = val[u] && (qsize(u) < 4);
            prev_data[u] = din[u];
            prev_en[u]   = en[u];
            prev_sck[u]  = sck[u];
        end
    endtask

    // Offer one sample with a handshake; returns one cycle after acceptance
    task automatic applyStimulus(input int u, input logic [15:0] d);
        din[u] = d;
        val[u] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (ready[u]) break;
        end
        checkOutput("push_accept", u, 32'(ready[u]), 32'd1);
        @(posedge clk);
        #1;
        val[u] = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitFrames(input int u, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (frames_done[u] >= target) break;
        end
        #1;
        checkOutput("frames_done", u, 32'(frames_done[u]), 32'(target));
    endtask

    task automatic waitRise(input int u, input int n);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (in_frame[u] && rises[u] == n) break;
        end
        #1;
        checkOutput("rise_wait", u, 32'(rises[u]), 32'(n));
    endtask

    // Directed sequence; the reference model runs alongside it as a forked loop
    initial begin
        int          base;
        logic [15:0] r;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int u = 0; u < 2; u++) begin
            rst_n[u]       = 1'b0;
            en[u]          = 1'b0;
            val[u]         = 1'b0;
            din[u]         = 16'd0;
            in_frame[u]    = 1'b0;
            prev_push[u]   = 1'b0;
            prev_en[u]     = 1'b0;
            prev_sck[u]    = 1'b0;
            prev_data[u]   = 16'd0;
            cur_word[u]    = 16'd0;
            rx[u]          = 16'd0;
            last_rx[u]     = 16'd0;
            t0[u]          = 0;
            last_fall[u]   = -1000;
            rises[u]       = 0;
            frames_done[u] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                cyc++;
                monitorUnit(0);
                monitorUnit(1);
            end
        join_none

        idleCycles(3);
        $display("[TB] releasing reset");
        for (int u = 0; u < 2; u++) rst_n[u] = 1'b1;
        idleCycles(2);

        $display("[TB] single sample A5C3");
        en[0] = 1'b1;
        base  = frames_done[0];
        applyStimulus(0, 16'hA5C3);
        waitFrames(0, base + 1, 400);
        checkOutput("word_a5c3", 0, 32'(last_rx[0]), 32'h0000A5C3);

        $display("[TB] loopback trio");
        base = frames_done[0];
        applyStimulus(0, 16'h7FFF);
        applyStimulus(0, 16'h8000);
        applyStimulus(0, 16'h0001);
        waitFrames(0, base + 3, 1200);
        checkOutput("word_0001", 0, 32'(last_rx[0]), 32'h00000001);

        $display("[TB] random samples with random spacing");
        base = frames_done[0];
        for (int i = 0; i < 6; i++) begin
            idleCycles($urandom_range(0, 150));
            r = 16'($urandom);
            applyStimulus(0, r);
        end
        waitFrames(0, base + 6, 2000);

        $display("[TB] back-pressure with enable low");
        idleCycles(10);
        en[0] = 1'b0;
        base  = frames_done[0];
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            applyStimulus(0, r);
        end
        din[0] = 16'($urandom);
        val[0] = 1'b1;
        idleCycles(3);
        checkOutput("full_ready", 0, 32'(ready[0]), 32'd0);
        checkOutput("full_level", 0, 32'(lvl[0]),   32'd4);
        en[0] = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (ready[0]) break;
        end
        checkOutput("fifth_accept", 0, 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1;
        val[0] = 1'b0;
        waitFrames(0, base + 5, 2000);

        $display("[TB] enable drop mid-frame");
        base = frames_done[0];
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            applyStimulus(0, r);
        end
        waitRise(0, 5);
        en[0] = 1'b0;
        waitFrames(0, base + 1, 400);
        idleCycles(300);
        checkOutput("held_level", 0, 32'(lvl[0]), 32'd2);
        checkOutput("held_frames", 0, 32'(frames_done[0]), 32'(base + 1));
        en[0] = 1'b1;
        waitFrames(0, base + 3, 800);

        $display("[TB] reset mid-frame");
        idleCycles(10);
        applyStimulus(0, 16'($urandom));
        applyStimulus(0, 16'($urandom));
        waitRise(0, 8);
        rst_n[0] = 1'b0;
        #1;
        checkOutput("abort_active", 0, 32'(act[0]), 32'd0);
        checkOutput("abort_sclk",   0, 32'(sck[0]), 32'd0);
        checkOutput("abort_mosi",   0, 32'(mo[0]),  32'd0);
        checkOutput("abort_level",  0, 32'(lvl[0]), 32'd0);
        idleCycles(2);
        rst_n[0] = 1'b1;
        idleCycles(3);
        base = frames_done[0];
        r    = 16'($urandom);
        applyStimulus(0, r);
        waitFrames(0, base + 1, 400);
        checkOutput("post_reset_word", 0, 32'(last_rx[0]), 32'(r));

        $display("[TB] fast instance CLK_DIV=2 GAP_CYCLES=2");
        en[1] = 1'b1;
        base  = frames_done[1];
        applyStimulus(1, 16'h1234);
        r = 16'($urandom);
        applyStimulus(1, r);
        waitFrames(1, base + 2, 400);
        checkOutput("fast_word", 1, 32'(last_rx[1]), 32'(r));
        base = frames_done[1];
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'($urandom));
        waitFrames(1, base + 4, 800);

        idleCycles(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
